// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM encoding, BCD digit constants and a constant clog2 for the binary-to-BCD converter
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int BCD_DIGIT_W = 4;
  localparam int ADJ_THRESH  = 5;
  localparam int ADJ_ADD     = 3;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: combinational double-dabble digit correction, d_o = d_i + 3 when d_i >= 5 (4-bit, carry dropped)
//   d_i  in  4  BCD digit before the shift
//   d_o  out 4  corrected digit
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_i,
  output logic [BCD_DIGIT_W-1:0] d_o
);
  assign d_o = d_i >= BCD_DIGIT_W'(ADJ_THRESH) ? d_i + BCD_DIGIT_W'(ADJ_ADD) : d_i;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential shift-and-add-3 binary-to-BCD converter with start/busy/done handshake
//   clk, rst (async, active high); start/bin_in request a conversion when idle;
//   busy high while converting; done pulses one cycle when bcd_out (digit 0 in [3:0]) updates.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out
);
  localparam int CW = clog2(BIN_W);
  localparam int AW = BCD_DIGIT_W * DIGITS;
  if (10 ** DIGITS <= 2 ** BIN_W - 1) begin : g_bad_digits
    $error("DIGITS too small to hold the largest BIN_W value");
  end
  state_t          state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [AW-1:0]    acc_q, acc_d, adj, shifted, bcd_q, bcd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d, load, shifting, last;
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i(acc_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .d_o(adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end
  assign load     = state_q == IDLE && start;
  assign shifting = state_q == SHIFT;
  assign last     = cnt_q == CW'(BIN_W - 1);
  // corrected accumulator shifted left, pulling in the next binary MSB
  assign shifted  = {adj[AW-2:0], bin_q[BIN_W-1]};
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  always_comb
    state_d = state_q == IDLE  ? (start ? SHIFT : IDLE) :
              state_q == SHIFT ? (last ? DONE : SHIFT) : IDLE;
  always_comb begin
    bin_d  = load ? bin_in : shifting ? {bin_q[BIN_W-2:0], 1'b0} : bin_q;
    acc_d  = load ? '0 : shifting ? shifted : acc_q;
    cnt_d  = load ? '0 : shifting ? cnt_q + 1'b1 : cnt_q;
    bcd_d  = shifting && last ? shifted : bcd_q;
    done_d = shifting && last;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bin_q  <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      bcd_q  <= '0;
      done_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      bcd_q  <= bcd_d;
      done_q <= done_d;
    end
  assign busy    = state_q != IDLE;
  assign done    = done_q;
  assign bcd_out = bcd_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: randomized and directed self-checking bench for bin_to_bcd_seq against an arithmetic BCD model
module tb_bin_to_bcd_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] bin_in = '0;
  logic        busy, done;
  logic [15:0] bcd_out;
  int checks = 0;
  int errors = 0;

  bin_to_bcd_seq #(.BIN_W(12), .DIGITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Drives one start pulse; returns cycles from accepting edge to done, the result,
  // whether bcd_out moved before done, and busy/done one edge after done.
  task automatic run_conv(input int v, output int lat, output logic [15:0] res,
                          output logic changed, output logic busy_acc,
                          output logic done_nx, output logic busy_nx);
    logic [15:0] prev;
    @(negedge clk);
    bin_in = 12'(v);
    start  = 1'b1;
    @(posedge clk);
    #1;
    busy_acc = busy;
    prev     = bcd_out;
    changed  = 1'b0;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 12'($urandom);
    lat = 99;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
      if (bcd_out !== prev) changed = 1'b1;
    end
    res = bcd_out;
    @(posedge clk);
    #1;
    done_nx = done;
    busy_nx = busy;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b bcd=%h, expected 0 0 0000", busy, done, bcd_out);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed;
    int vals[4] = '{0, 4095, 999, 1234};
    int lat;
    logic [15:0] res;
    logic ch, ba, dn, bn;
    foreach (vals[i]) begin
      run_conv(vals[i], lat, res, ch, ba, dn, bn);
      checks++;
      if (lat !== 12 || res !== ref_bcd(vals[i])) begin
        errors++;
        $display("FAIL directed_%0d: latency=%0d bcd=%h, expected 12 %h", vals[i], lat, res, ref_bcd(vals[i]));
      end
      checks++;
      if (ba !== 1'b1 || dn !== 1'b0 || bn !== 1'b0 || ch !== 1'b0) begin
        errors++;
        $display("FAIL handshake_%0d: busy_acc=%b done_after=%b busy_after=%b partial=%b, expected 1 0 0 0",
                 vals[i], ba, dn, bn, ch);
      end
    end
  endtask

  task automatic test_back_to_back;
    int hits[$];
    logic bad_val;
    bad_val = 1'b0;
    @(negedge clk);
    bin_in = 12'd10;
    start  = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        hits.push_back(i);
        if (bcd_out !== 16'h0010) bad_val = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (hits.size() != 4 || hits[0] != 12) begin
      errors++;
      $display("FAIL b2b_count: pulses=%0d first=%0d, expected 4 12", hits.size(), hits.size() > 0 ? hits[0] : -1);
    end
    for (int i = 1; i < hits.size(); i++) begin
      checks++;
      if (hits[i] - hits[i-1] != 14) begin
        errors++;
        $display("FAIL b2b_period: gap=%0d, expected 14", hits[i] - hits[i-1]);
      end
    end
    checks++;
    if (bad_val) begin
      errors++;
      $display("FAIL b2b_value: bcd not 0010 on a done pulse, expected 0010");
    end
    for (int i = 0; i < 30 && busy; i++) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_ignore_start;
    int v, lat;
    v = 1234 + int'($urandom_range(0, 2000));
    @(negedge clk);
    bin_in = 12'(v);
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 99;
    for (int n = 1; n <= 40; n++) begin
      if (n == 5) begin
        start  = 1'b1;
        bin_in = 12'd7;
      end else start = 1'b0;
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (lat !== 12 || bcd_out !== ref_bcd(v)) begin
      errors++;
      $display("FAIL ignore_start: latency=%0d bcd=%h, expected 12 %h", lat, bcd_out, ref_bcd(v));
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== ref_bcd(v)) begin
      errors++;
      $display("FAIL ignore_in_done: busy=%b done=%b bcd=%h, expected 0 0 %h", busy, done, bcd_out, ref_bcd(v));
    end
  endtask

  task automatic test_rst_abort;
    int lat;
    logic [15:0] res;
    logic ch, ba, dn, bn;
    @(negedge clk);
    bin_in = 12'd500;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 16'h0) begin
      errors++;
      $display("FAIL rst_abort: busy=%b done=%b bcd=%h, expected 0 0 0000", busy, done, bcd_out);
    end
    @(negedge clk);
    rst = 1'b0;
    run_conv(500, lat, res, ch, ba, dn, bn);
    checks++;
    if (lat !== 12 || res !== 16'h0500) begin
      errors++;
      $display("FAIL rst_restart: latency=%0d bcd=%h, expected 12 0500", lat, res);
    end
  endtask

  task automatic test_random;
    int v, lat;
    logic [15:0] res;
    logic ch, ba, dn, bn;
    for (int i = 0; i < 40; i++) begin
      v = int'($urandom_range(0, 4095));
      run_conv(v, lat, res, ch, ba, dn, bn);
      checks++;
      if (lat !== 12 || res !== ref_bcd(v) || ch !== 1'b0 || dn !== 1'b0) begin
        errors++;
        $display("FAIL random_%0d: latency=%0d bcd=%h partial=%b done_after=%b, expected 12 %h 0 0",
                 v, lat, res, ch, dn, ref_bcd(v));
      end
    end
  endtask

  task automatic test_sweep;
    int lat;
    logic [15:0] res;
    logic ch, ba, dn, bn, digit_bad;
    for (int v = 0; v < 4096; v++) begin
      run_conv(v, lat, res, ch, ba, dn, bn);
      digit_bad = 1'b0;
      for (int d = 0; d < 4; d++) if (res[4*d +: 4] > 4'd9) digit_bad = 1'b1;
      checks++;
      if (lat !== 12 || res !== ref_bcd(v) || digit_bad) begin
        errors++;
        $display("FAIL sweep_%0d: latency=%0d bcd=%h, expected 12 %h", v, lat, res, ref_bcd(v));
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_ignore_start;
    test_rst_abort;
    test_random;
    test_sweep;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
